// File: rtl/str_frame_packer.sv
// str_frame_packer: packs a signed sample stream into packets of 32-bit words: header {SYNC, seq}, one
//   sign-extended word per sample, and (with FRAME_CHECKSUM_EN defined) a wrap-around sum trailer.
// Latency: a sample accepted on an edge is on m_axis_tdata right after that edge; the header costs one extra cycle per frame.
// Backpressure: one output register; s_axis_tready is high only in DATA, and only while that register is empty or draining.
// Ports: clk, rst (synchronous, active-high); s_axis_* sample input with tlast marking the end of a frame;
//   m_axis_* packet output with tlast on the final word; len_err is sticky and set when a frame length differs
//   from FRAME_LEN; seq is the sequence number carried by the next header.
// Option: `define FRAME_CHECKSUM_EN adds the TRAILER state and the checksum adder.
module str_frame_packer #(
  parameter int          DW        = 24,
  parameter int          FRAME_LEN = 16000,
  parameter logic [15:0] SYNC      = 16'hA55A
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] s_axis_tdata,
  input  logic          s_axis_tvalid,
  output logic          s_axis_tready,
  input  logic          s_axis_tlast,
  output logic [31:0]   m_axis_tdata,
  output logic          m_axis_tvalid,
  input  logic          m_axis_tready,
  output logic          m_axis_tlast,
  output logic          len_err,
  output logic [15:0]   seq
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] HEADER  = 2'd1;
  localparam logic [1:0] DATA    = 2'd2;
`ifdef FRAME_CHECKSUM_EN
  localparam logic [1:0] TRAILER = 2'd3;
`endif

  localparam logic [15:0] FRAME_LEN_W = 16'(FRAME_LEN);

  logic [1:0]  state;
  logic [15:0] cnt;
  logic [15:0] cnt_inc;
  logic [15:0] seq_nxt;
  logic [31:0] s_ext;
  logic        can_load;
  logic        s_hs;
  logic        last_hs;
`ifdef FRAME_CHECKSUM_EN
  logic [31:0] csum;
`endif

  // The output register can take a new word when it is empty or its word leaves this cycle.
  assign can_load      = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = (state == DATA) && can_load;
  assign s_hs          = s_axis_tvalid && s_axis_tready;
  assign last_hs       = m_axis_tvalid && m_axis_tready && m_axis_tlast;

  // A header may be loaded in the same cycle the previous packet's last word leaves,
  // so the header takes the already-incremented sequence number.
  assign seq_nxt = last_hs ? seq + 16'd1 : seq;
  assign s_ext   = 32'($signed(s_axis_tdata));
  assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      len_err       <= 1'b0;
      seq           <= '0;
      cnt           <= '0;
`ifdef FRAME_CHECKSUM_EN
      csum          <= '0;
`endif
    end else begin
      seq <= seq_nxt;
      // Accepted word leaves; any load below in the same cycle overrides this.
      if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      case (state)
        IDLE: begin
          // Only looks at tvalid; the sample itself waits for DATA.
          if (s_axis_tvalid) begin
            state <= HEADER;
          end
        end
        HEADER: begin
          if (can_load) begin
            m_axis_tdata  <= {SYNC, seq_nxt};
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= 1'b0;
            cnt           <= '0;
`ifdef FRAME_CHECKSUM_EN
            csum          <= {SYNC, seq_nxt};
`endif
            state         <= DATA;
          end
        end
        DATA: begin
          if (s_hs) begin
            m_axis_tdata  <= s_ext;
            m_axis_tvalid <= 1'b1;
            cnt           <= cnt_inc;
`ifdef FRAME_CHECKSUM_EN
            csum          <= csum + s_ext;
`endif
            if (s_axis_tlast) begin
              if (cnt_inc != FRAME_LEN_W) begin
                len_err <= 1'b1;
              end
`ifdef FRAME_CHECKSUM_EN
              m_axis_tlast <= 1'b0;
              state        <= TRAILER;
`else
              m_axis_tlast <= 1'b1;
              state        <= IDLE;
`endif
            end else begin
              m_axis_tlast <= 1'b0;
            end
          end
        end
`ifdef FRAME_CHECKSUM_EN
        TRAILER: begin
          if (can_load) begin
            m_axis_tdata  <= csum;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= 1'b1;
            state         <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_str_frame_packer.sv
`timescale 1ns/1ps
module tb_str_frame_packer;

  localparam int          DW   = 24;
  localparam int          FL   = 4;
  localparam logic [15:0] SYNC = 16'hA55A;
`ifdef FRAME_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic [31:0]   m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic          len_err;
  logic [15:0]   seq;

  str_frame_packer #(.DW(DW), .FRAME_LEN(FL), .SYNC(SYNC)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .len_err(len_err), .seq(seq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] din;
    logic          last;
    logic [31:0]   exp;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int rdy_mode = 0;  // 0: always ready, 1: toggle, 2: random

  // Reference model: each frame becomes header, data words, optional sum trailer.
  logic [32:0]   exp_q[$];
  logic [32:0]   got_q[$];
  int            got_cyc[$];
  logic [DW-1:0] frame_q[$];
  logic [15:0]   m_seq;
  logic          m_len_err;

  function automatic logic [31:0] sext(input logic [DW-1:0] d);
    return {{(32-DW){d[DW-1]}}, d};
  endfunction

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic monitor();
    logic        prev_stall;
    logic [32:0] prev_w;
    prev_stall = 1'b0;
    prev_w     = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_valid", 33'(m_axis_tvalid), 33'd1);
          chk("stall_word", {m_axis_tlast, m_axis_tdata}, prev_w);
        end
        if (m_axis_tvalid && m_axis_tready) begin
          got_q.push_back({m_axis_tlast, m_axis_tdata});
          got_cyc.push_back(cyc);
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_w     = {m_axis_tlast, m_axis_tdata};
      end
    end
  endtask

  task automatic rdy_driver();
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = ~m_axis_tready;
        default: m_axis_tready = ($urandom_range(3) != 0);
      endcase
    end
  endtask

  // Entered and left at posedge+1.
  task automatic send_sample(input logic [DW-1:0] d, input logic lst, input int bub);
    int guard;
    bit ok;
    while (bub > 0 && int'($urandom_range(99)) < bub) begin
      s_axis_tvalid = 1'b0;
      @(posedge clk); #1;
    end
    s_axis_tdata  = d;
    s_axis_tlast  = lst;
    s_axis_tvalid = 1'b1;
    ok    = 1'b0;
    guard = 0;
    while (!ok && guard < 500) begin
      @(negedge clk);
      ok = s_axis_tready;
      @(posedge clk); #1;
      guard++;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    if (!ok) chk("sample_accept_timeout", 33'd0, 33'd1);
    else     chk("latency1_word", {m_axis_tvalid, m_axis_tdata}, {1'b1, sext(d)});
  endtask

  task automatic send_frame(input int bub);
    logic [31:0] w, sum;
    w   = {SYNC, m_seq};
    sum = w;
    exp_q.push_back({1'b0, w});
    for (int i = 0; i < frame_q.size(); i++) begin
      w   = sext(frame_q[i]);
      sum = sum + w;
      exp_q.push_back({(!CSUM && i == frame_q.size() - 1), w});
    end
    if (CSUM) exp_q.push_back({1'b1, sum});
    if (frame_q.size() != FL) m_len_err = 1'b1;
    m_seq = m_seq + 16'd1;
    for (int i = 0; i < frame_q.size(); i++)
      send_sample(frame_q[i], (i == frame_q.size() - 1), bub);
    frame_q.delete();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (got_q.size() < exp_q.size() && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_words", 33'(got_q.size() >= exp_q.size()), 33'd1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic compare_all(input string tag);
    chk({tag, "_count"}, 33'(got_q.size()), 33'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0)
      chk({tag, "_word"}, got_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    got_q.delete();
    got_cyc.delete();
    chk({tag, "_seq"}, 33'(seq), 33'(m_seq));
    chk({tag, "_len_err"}, 33'(len_err), 33'(m_len_err));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tab[4];
    int   hdr_idx, nfr;
    tab[0] = '{24'd1,       1'b0, 32'h00000001};
    tab[1] = '{24'hFFFFFF,  1'b0, 32'hFFFFFFFF};
    tab[2] = '{24'd2,       1'b0, 32'h00000002};
    tab[3] = '{24'd3,       1'b1, 32'h00000003};

    rst = 1'b1; s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0;
    m_axis_tready = 1'b1;
    m_seq = '0; m_len_err = 1'b0;
    fork
      monitor();
      rdy_driver();
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", 33'(m_axis_tvalid), 33'd0);
    chk("rst_tdata",  33'(m_axis_tdata),  33'd0);
    chk("rst_tlast",  33'(m_axis_tlast),  33'd0);
    chk("rst_tready", 33'(s_axis_tready), 33'd0);
    chk("rst_len_err", 33'(len_err),      33'd0);
    chk("rst_seq",    33'(seq),           33'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic frame, always ready, table-driven
    for (int i = 0; i < 4; i++) frame_q.push_back(tab[i].din);
    send_frame(0);
    drain();
    chk("basic_header", got_q[0], {1'b0, 32'hA55A0000});
    for (int i = 0; i < 4; i++)
      chk("basic_data", got_q[1 + i], {(!CSUM && tab[i].last), tab[i].exp});
    if (CSUM) chk("basic_trailer", got_q[5], {1'b1, 32'hA55A0005});
    chk("basic_seq_is_1", 33'(seq), 33'd1);
    compare_all("basic");

    // Same stream with ready toggling every cycle
    rdy_mode = 1;
    for (int i = 0; i < 4; i++) frame_q.push_back(tab[i].din);
    send_frame(0);
    drain();
    compare_all("toggle");
    rdy_mode = 0;
    @(posedge clk); #1;

    // Short frame sets len_err; it sticks through correct frames sent back-to-back
    frame_q = '{24'd10, 24'd11, 24'd12};
    send_frame(0);
    drain();
    chk("short_len_err", 33'(len_err), 33'd1);
    compare_all("short");
    frame_q = '{24'd20, 24'd21, 24'd22, 24'd23};
    send_frame(0);
    frame_q = '{24'd30, 24'd31, 24'd32, 24'd33};
    send_frame(0);
    drain();
    hdr_idx = CSUM ? 6 : 5;
    chk("b2b_gap_le_1", 33'((got_cyc[hdr_idx] - got_cyc[hdr_idx - 1]) <= 2), 33'd1);
    chk("sticky_len_err", 33'(len_err), 33'd1);
    compare_all("b2b");

    // Two-sample frame: last word flag placement
    frame_q = '{24'd5, 24'd6};
    send_frame(0);
    drain();
    chk("two_count", 33'(got_q.size()), CSUM ? 33'd4 : 33'd3);
    chk("two_last_word", got_q[2], {!CSUM, 32'h00000006});
    compare_all("two");

    // Sequence wrap
    @(negedge clk);
    force dut.seq = 16'hFFFF;
    @(posedge clk); #1;
    release dut.seq;
    @(posedge clk); #1;
    chk("forced_seq", 33'(seq), 33'h0FFFF);
    m_seq = 16'hFFFF;
    frame_q = '{24'd1, 24'd2, 24'd3, 24'd4};
    send_frame(0);
    frame_q = '{24'd5, 24'd6, 24'd7, 24'd8};
    send_frame(0);
    drain();
    chk("wrap_hdr_ffff", got_q[0], {1'b0, 32'hA55AFFFF});
    chk("wrap_hdr_0000", got_q[CSUM ? 6 : 5], {1'b0, 32'hA55A0000});
    compare_all("wrap");

    // Reset in the middle of a packet
    send_sample(24'd1, 1'b0, 0);
    send_sample(24'd2, 1'b0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_words", 33'(got_q.size()), 33'd3);
    chk("pre_rst_hdr", got_q[0], {1'b0, SYNC, m_seq});
    chk("pre_rst_w2", got_q[2], {1'b0, 32'h00000002});
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("post_rst_tvalid", 33'(m_axis_tvalid), 33'd0);
    chk("post_rst_seq", 33'(seq), 33'd0);
    chk("post_rst_len_err", 33'(len_err), 33'd0);
    got_q.delete(); got_cyc.delete(); exp_q.delete();
    m_seq = '0; m_len_err = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("no_trailer_after_rst", 33'(got_q.size()), 33'd0);
    frame_q = '{24'd7, 24'd8, 24'd9, 24'd10};
    send_frame(0);
    drain();
    chk("post_rst_hdr", got_q[0], {1'b0, 32'hA55A0000});
    compare_all("post_rst");

    // Randomized frames, bubbles and backpressure
    rdy_mode = 2;
    for (int f = 0; f < 14; f++) begin
      nfr = $urandom_range(1, 6);
      for (int i = 0; i < nfr; i++) begin
        case ($urandom_range(5))
          0:       frame_q.push_back(24'h800000);
          1:       frame_q.push_back(24'h7FFFFF);
          default: frame_q.push_back(DW'($urandom));
        endcase
      end
      send_frame(30);
    end
    drain();
    compare_all("random");
    rdy_mode = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
